// File: rtl/pl_pkg.sv
// Shared definitions for the pipeline store buffer: default depth, word-address
// slice bounds and the buffered-entry record.
package pl_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned WA_HI    = 31;
    localparam int unsigned WA_LO    = 2;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } sb_entry_t;

    // Word address of a byte address; the two byte-offset bits are dropped.
    function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr[WA_HI:WA_LO];
    endfunction

endpackage

// File: rtl/pl_sb_fwd.sv
// Store-to-load forwarding search: finds the youngest valid buffered store whose
// word address matches the load, scanning from tail backward.
module pl_sb_fwd
    import pl_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  sb_entry_t [DEPTH-1:0]         i_entries,
    input  logic [$clog2(DEPTH)-1:0]      i_tail,
    input  logic [$clog2(DEPTH+1)-1:0]    i_count,
    input  logic [29:0]                   i_ld_waddr,
    output logic                          o_hit,
    output logic [31:0]                   o_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] w_idx;

    // Oldest candidate first so that a younger match overwrites an older one.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = i_tail - PW'(k);
            if ((CW'(k) <= i_count) && (i_entries[w_idx].addr == i_ld_waddr)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/pl_store_buffer.sv
// Word-wide store buffer between the MEM stage and data memory: queues stores,
// retires them when the memory port is free, and forwards buffered data to loads.
module pl_store_buffer
    import pl_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic [31:0] ld_data,
    output logic        stall,
    output logic        empty,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic        mem_we,
    input  logic [31:0] mem_dataout
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH-1:0] r_entries;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_next;

    logic      w_full;
    logic      w_empty;
    logic      w_drain;
    logic      w_push;
    logic      w_fwd_hit;
    logic [31:0] w_fwd_data;
    sb_entry_t w_head_entry;

    assign w_full       = (r_count == CW'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_head_entry = r_entries[r_head];

    // A load owns the memory port unless a store is presented in the same cycle.
    assign w_drain = ~w_empty & mem_ready & ~(ld_valid & ~st_valid);
    assign w_push  = st_valid & (~w_full | w_drain);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_drain) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_drain) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_drain) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Entry storage is deliberately not reset; validity comes from the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entries[r_tail] <= '{addr: word_addr(st_addr), data: st_data};
        end
    end

    pl_sb_fwd #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .i_entries  (r_entries),
        .i_tail     (r_tail),
        .i_count    (r_count),
        .i_ld_waddr (word_addr(ld_addr)),
        .o_hit      (w_fwd_hit),
        .o_data     (w_fwd_data)
    );

    assign ld_data    = w_fwd_hit ? w_fwd_data : mem_dataout;
    assign stall      = st_valid & w_full & ~w_drain;
    assign empty      = w_empty;
    assign mem_we     = w_drain;
    assign mem_addr   = w_drain ? {w_head_entry.addr, 2'b00} : ld_addr;
    assign mem_datain = w_head_entry.data;

endmodule

// File: tb/tb_pl_store_buffer.sv
// Directed self-checking bench for pl_store_buffer (DEPTH = 4).
module tb_pl_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        stall;
    logic        empty;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic        mem_we;
    logic [31:0] mem_dataout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pl_store_buffer #(
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .stall       (stall),
        .empty       (empty),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .mem_we      (mem_we),
        .mem_dataout (mem_dataout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
    endtask

    initial begin
        rst = 1'b1; st_valid = 0; st_addr = 0; st_data = 0;
        ld_valid = 0; ld_addr = 0; mem_ready = 1; mem_dataout = 0;
        #12 rst = 1'b0;
        #1;
        // Reset then idle
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        ld_valid = 1; ld_addr = 32'h50; mem_dataout = 32'h000000a3;
        #1;
        chk("idle_ld", ld_data, 32'h000000a3);
        chk("idle_maddr", mem_addr, 32'h50);

        // Store then drain
        tick();
        ld_valid = 0; mem_ready = 1;
        store(32'h60, 32'h258);
        #1;
        chk("sd_stall", {31'b0, stall}, 32'd0);
        chk("sd_we0", {31'b0, mem_we}, 32'd0);
        tick();
        st_valid = 0;
        #1;
        chk("sd_we", {31'b0, mem_we}, 32'd1);
        chk("sd_addr", mem_addr, 32'h60);
        chk("sd_data", mem_datain, 32'h258);
        chk("sd_nempty", {31'b0, empty}, 32'd0);
        tick();
        chk("sd_empty", {31'b0, empty}, 32'd1);
        chk("sd_we_off", {31'b0, mem_we}, 32'd0);

        // Forwarding youngest
        mem_ready = 0;
        store(32'h60, 32'h11);
        tick();
        store(32'h60, 32'h22);
        tick();
        st_valid = 0; ld_valid = 1; ld_addr = 32'h60; mem_dataout = 32'hdeadbeef;
        #1;
        chk("fw_young", ld_data, 32'h22);
        ld_addr = 32'h61;
        #1;
        chk("fw_lowbits", ld_data, 32'h22);
        ld_addr = 32'h64;
        #1;
        chk("fw_miss", ld_data, 32'hdeadbeef);
        ld_valid = 0; mem_ready = 1;
        #1;
        chk("fw_dr1_addr", mem_addr, 32'h60);
        chk("fw_dr1_data", mem_datain, 32'h11);
        tick();
        chk("fw_dr2_data", mem_datain, 32'h22);
        ld_valid = 1; ld_addr = 32'h60; mem_dataout = 32'h77;
        #1;
        chk("fw_after_pop", ld_data, 32'h22);
        ld_valid = 0;
        tick();
        chk("fw_empty", {31'b0, empty}, 32'd1);

        // Full / stall
        mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            store(32'h100 + 32'(4 * i), 32'ha0 + 32'(i));
            #1;
            chk("full_fill_stall", {31'b0, stall}, 32'd0);
            tick();
        end
        store(32'h110, 32'ha4);
        #1;
        chk("full_stall", {31'b0, stall}, 32'd1);
        tick();
        chk("full_stall_hold", {31'b0, stall}, 32'd1);
        mem_ready = 1;
        #1;
        chk("full_pp_stall", {31'b0, stall}, 32'd0);
        chk("full_pp_we", {31'b0, mem_we}, 32'd1);
        chk("full_pp_addr", mem_addr, 32'h100);
        chk("full_pp_data", mem_datain, 32'ha0);
        tick();
        mem_ready = 0;
        store(32'h200, 32'h5);
        #1;
        chk("full_still_full", {31'b0, stall}, 32'd1);
        st_valid = 0; ld_valid = 1; ld_addr = 32'h110; mem_dataout = 32'h99;
        #1;
        chk("full_fwd_5th", ld_data, 32'ha4);
        ld_addr = 32'h100;
        #1;
        chk("full_retired", ld_data, 32'h99);
        ld_valid = 0; mem_ready = 1;
        #1;
        chk("full_next_head", mem_addr, 32'h104);
        chk("full_next_data", mem_datain, 32'ha1);
        tick();
        chk("full_dr_108", mem_addr, 32'h108);
        tick();

        // Load blocks drain: 0x10c and 0x110 remain
        ld_valid = 1; ld_addr = 32'h200; mem_dataout = 32'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lb_we", {31'b0, mem_we}, 32'd0);
            chk("lb_addr", mem_addr, 32'h200);
            chk("lb_data", ld_data, 32'h55);
            tick();
        end
        ld_addr = 32'h10c;
        #1;
        chk("lb_fwd", ld_data, 32'ha3);
        ld_valid = 0;
        #1;
        chk("lb_r1_addr", mem_addr, 32'h10c);
        chk("lb_r1_data", mem_datain, 32'ha3);
        tick();
        chk("lb_r2_addr", mem_addr, 32'h110);
        chk("lb_r2_data", mem_datain, 32'ha4);
        tick();
        chk("lb_empty", {31'b0, empty}, 32'd1);

        // Async reset mid-drain with three entries
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            store(32'h300 + 32'(4 * i), 32'hc0 + 32'(i));
            tick();
        end
        st_valid = 0; mem_ready = 1;
        #1;
        chk("ar_pre_we", {31'b0, mem_we}, 32'd1);
        chk("ar_pre_addr", mem_addr, 32'h300);
        #2 rst = 1'b1;
        #1;
        chk("ar_empty", {31'b0, empty}, 32'd1);
        chk("ar_we", {31'b0, mem_we}, 32'd0);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("ar_post_empty", {31'b0, empty}, 32'd1);
        chk("ar_post_we", {31'b0, mem_we}, 32'd0);
        tick();
        chk("ar_post2_we", {31'b0, mem_we}, 32'd0);
        ld_valid = 1; ld_addr = 32'h300; mem_dataout = 32'h1234;
        #1;
        chk("ar_stale_nofwd", ld_data, 32'h1234);
        ld_valid = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
